sram_axi_bridge: RTL

Bridges the core's two SRAM-like ports (inst fetch, data/MEM stage) onto one AXI3 master interface: arbitrates reads, sequences writes and routes responses back as data_ok. Sits between the pipeline (IF/EXE/MEM stages) and the SoC AXI crossbar. Fixed AXI fields (len=0, burst=INCR, lock/cache/prot=0, awid/wid=1, wlast=1) are tied at top level and are not ports.

---
 rtl/sram_axi_bridge.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/sram_axi_bridge.sv
// Bridges the core's SRAM-like fetch and data ports onto one AXI3 master.
// Reads share a single AR channel (data has priority); stores run on AW/W/B.
module sram_axi_bridge #(
    parameter logic [3:0] INST_ID = 4'd0,
    parameter logic [3:0] DATA_ID = 4'd1
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,

    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,

    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [2:0]  arsize,
    output logic        arvalid,
    input  logic        arready,

    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic        rvalid,
    output logic        rready,

    output logic [31:0] awaddr,
    output logic [2:0]  awsize,
    output logic        awvalid,
    input  logic        awready,

    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wvalid,
    input  logic        wready,

    input  logic        bvalid,
    output logic        bready
);

    typedef enum logic {AR_IDLE, AR_BUSY} ar_state_t;
    typedef enum logic [1:0] {W_IDLE, W_SEND, W_RESP} w_state_t;

    ar_state_t   ar_state;
    ar_state_t   ar_next;
    w_state_t    w_state;
    w_state_t    w_next;

    logic        inst_pend;
    logic        data_pend;
    logic        wr_pend;
    logic [29:0] wr_addr;

    logic        live;
    logic        raw_hazard;
    logic        load_acc;
    logic        inst_acc;
    logic        store_acc;
    logic        inst_hit;
    logic        data_hit;
    logic        b_hit;
    logic        send_done;

    assign live = ~reset;

    // A fetch must not overtake a pending store to the same word.
    assign raw_hazard = wr_pend & (inst_addr[31:2] == wr_addr);

    assign inst_hit = live & rvalid & (rid == INST_ID) & inst_pend;
    assign data_hit = live & rvalid & (rid == DATA_ID) & data_pend & ~wr_pend;

    assign send_done = (~awvalid | awready) & (~wvalid | wready);

    assign inst_addr_ok = inst_acc;
    assign data_addr_ok = load_acc | store_acc;
    assign inst_data_ok = inst_hit;
    assign data_data_ok = data_hit | b_hit;
    assign inst_rdata   = rdata;
    assign data_rdata   = rdata;
    assign rready       = 1'b1;
    assign bready       = 1'b1;

    always_comb begin
        ar_next  = ar_state;
        arvalid  = 1'b0;
        load_acc = 1'b0;
        inst_acc = 1'b0;
        case (ar_state)
            AR_IDLE: begin
                if (live & data_req & ~data_wr & ~data_pend) begin
                    load_acc = 1'b1;
                    ar_next  = AR_BUSY;
                end else if (live & inst_req & ~inst_pend & ~raw_hazard) begin
                    inst_acc = 1'b1;
                    ar_next  = AR_BUSY;
                end
            end
            AR_BUSY: begin
                arvalid = 1'b1;
                if (arready) begin
                    ar_next = AR_IDLE;
                end
            end
            default: ar_next = AR_IDLE;
        endcase
    end

    always_comb begin
        w_next    = w_state;
        store_acc = 1'b0;
        b_hit     = 1'b0;
        case (w_state)
            W_IDLE: begin
                if (live & data_req & data_wr & ~data_pend & ~load_acc) begin
                    store_acc = 1'b1;
                    w_next    = W_SEND;
                end
            end
            W_SEND: begin
                if (send_done) begin
                    w_next = W_RESP;
                end
            end
            W_RESP: begin
                if (live & bvalid) begin
                    b_hit  = 1'b1;
                    w_next = W_IDLE;
                end
            end
            default: w_next = W_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ar_state  <= AR_IDLE;
            w_state   <= W_IDLE;
            inst_pend <= 1'b0;
            data_pend <= 1'b0;
            wr_pend   <= 1'b0;
            wr_addr   <= '0;
            arid      <= '0;
            araddr    <= '0;
            arsize    <= '0;
            awaddr    <= '0;
            awsize    <= '0;
            awvalid   <= 1'b0;
            wdata     <= '0;
            wstrb     <= '0;
            wvalid    <= 1'b0;
        end else begin
            ar_state <= ar_next;
            w_state  <= w_next;

            if (load_acc) begin
                arid   <= DATA_ID;
                araddr <= data_addr;
                arsize <= {1'b0, data_size};
            end else if (inst_acc) begin
                arid   <= INST_ID;
                araddr <= inst_addr;
                arsize <= 3'd2;
            end

            if (inst_acc) begin
                inst_pend <= 1'b1;
            end else if (inst_hit) begin
                inst_pend <= 1'b0;
            end

            if (load_acc | store_acc) begin
                data_pend <= 1'b1;
            end else if (data_hit | b_hit) begin
                data_pend <= 1'b0;
            end

            if (store_acc) begin
                wr_pend <= 1'b1;
            end else if (b_hit) begin
                wr_pend <= 1'b0;
            end

            // AW and W complete independently; each valid drops on its own ready.
            if (store_acc) begin
                wr_addr <= data_addr[31:2];
                awaddr  <= data_addr;
                awsize  <= {1'b0, data_size};
                wdata   <= data_wdata;
                wstrb   <= data_wstrb;
                awvalid <= 1'b1;
                wvalid  <= 1'b1;
            end else begin
                if (awvalid & awready) begin
                    awvalid <= 1'b0;
                end
                if (wvalid & wready) begin
                    wvalid <= 1'b0;
                end
            end
        end
    end

endmodule
